// File: rtl/video_ula_if.sv
// CPU write bus into the video ULA.
// The ULA is write-only; the CPU side is the master.
interface video_ula_if;
    logic       PROC_en;
    logic       nCS_VULA;
    logic       A0;
    logic [7:0] pDATA;

    modport master (
        output PROC_en,
        output nCS_VULA,
        output A0,
        output pDATA
    );

    modport slave (
        input PROC_en,
        input nCS_VULA,
        input A0,
        input pDATA
    );
endinterface

// File: rtl/video_ula.sv
// Video ULA: character clock, screen byte serialiser, palette,
// flash, cursor sequencer and teletext select.
module video_ula (
    input  logic        CLK,
    input  logic        nRESET,
    video_ula_if.slave  bus,
    input  logic [7:0]  vDATA,
    input  logic        DISEN,
    input  logic        CURSOR,
    input  logic [2:0]  TTX_RGB,
    output logic        CRTC_en,
    output logic [2:0]  RGB
);
    typedef enum logic [2:0] {
        C_IDLE, C_S0, C_S1, C_S2, C_S3
    } cur_t;

    logic [7:0] ctrl;
    logic [3:0] pal [16];
    logic [3:0] ph;
    logic [7:0] sr;
    logic       den;
    cur_t       cur;
    logic       wr;
    logic       pe;
    logic       cur_act;
    logic [3:0] idx;
    logic [3:0] pc;
    logic [2:0] col;

    assign wr      = ~bus.nCS_VULA & bus.PROC_en;
    assign CRTC_en = ctrl[4] ? (ph[2:0] == 3'd7) : (ph == 4'd15);
    assign idx     = {sr[7], sr[5], sr[3], sr[1]};
    assign pc      = pal[idx];
    assign col     = pc[2:0] ^ 3'b111 ^ {3{pc[3] & ctrl[0]}};

    // Pixel enable at the selected pixel rate.
    always_comb begin
        pe = 1'b0;
        unique case (ctrl[3:2])
            2'b11:   pe = 1'b1;
            2'b10:   pe = ph[0];
            2'b01:   pe = &ph[1:0];
            default: pe = &ph[2:0];
        endcase
    end

    // Cursor inversion for the current segment.
    always_comb begin
        cur_act = 1'b0;
        unique case (cur)
            C_S0:    cur_act = ctrl[7];
            C_S1:    cur_act = ctrl[6];
            C_S2:    cur_act = ctrl[5];
            C_S3:    cur_act = ctrl[5];
            default: cur_act = 1'b0;
        endcase
    end

    // CPU writes to control and palette registers.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            ctrl <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                pal[i] <= 4'h0;
            end
        end else if (wr) begin
            if (bus.A0) begin
                pal[bus.pDATA[7:4]] <= bus.pDATA[3:0];
            end else begin
                ctrl <= bus.pDATA;
            end
        end
    end

    // Free-running phase; never reset by ctrl changes.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            ph <= 4'd0;
        end else begin
            ph <= ph + 4'd1;
        end
    end

    // Load a screen byte per character, shift in ones per pixel.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            sr  <= 8'h00;
            den <= 1'b0;
        end else if (CRTC_en) begin
            sr  <= DISEN ? vDATA : 8'h00;
            den <= DISEN;
        end else if (pe) begin
            sr  <= {sr[6:0], 1'b1};
        end
    end

    // Cursor segment sequencer, stepped by the character clock.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            cur <= C_IDLE;
        end else if (CRTC_en) begin
            if (CURSOR) begin
                cur <= C_S0;
            end else begin
                unique case (cur)
                    C_S0:    cur <= C_S1;
                    C_S1:    cur <= C_S2;
                    C_S2:    cur <= C_S3;
                    default: cur <= C_IDLE;
                endcase
            end
        end
    end

    // Registered pixel output.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            RGB <= 3'b000;
        end else begin
            RGB <= (ctrl[1] ? TTX_RGB : (den ? col : 3'b000))
                   ^ {3{cur_act}};
        end
    end
endmodule
